uv_i2c_slv: RTL and testbench

I2C target (slave) controller: the responder end of the same two-wire bus the SoC's I2C controller drives. It monitors SCL/SDA, detects START/STOP, matches a fixed 7-bit address, and moves data bytes through a byte-wide valid/ready interface. It holds SCL low (clock stretching) whenever its local side cannot keep up. It sits between the pad muxing and a local register file or DMA front end.

---
 rtl/uv_i2c_pkg.sv | 16 +
 rtl/uv_i2c_slv_sync.sv | 40 ++++
 rtl/uv_i2c_slv.sv | 191 +++++++++++++++++++
 tb/tb_uv_i2c_slv.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uv_i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants
// common to the controller and target.
package uv_i2c_pkg;
   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK,
      ST_RD_LOAD, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
   } slv_state_e;

   localparam logic       I2C_ACK  = 1'b0;
   localparam logic       I2C_NACK = 1'b1;
   localparam int         RW_BIT   = 0;
   // Bit counter milestones: last data bit, ACK slot, ACK slot finished
   localparam logic [3:0] LAST_BIT = 4'd7;
   localparam logic [3:0] ACK_SLOT = 4'd8;
   localparam logic [3:0] ACK_DONE = 4'd9;
endpackage

// File: rtl/uv_i2c_slv_sync.sv
// SCL/SDA synchronizer with edge and START/STOP detection.
module uv_i2c_slv_sync #(
   parameter int SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);
   logic [SYNC_STG-1:0] r_scl_sync, r_sda_sync;
   logic                r_scl_d, r_sda_d;
   logic                w_scl;

   // Idle bus level is high, so reset everything to 1 to avoid false edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= o_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STG-1];
   assign o_sda      = r_sda_sync[SYNC_STG-1];
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   assign o_start    = w_scl & r_scl_d & r_sda_d & ~o_sda;
   assign o_stop     = w_scl & r_scl_d & ~r_sda_d & o_sda;
endmodule

// File: rtl/uv_i2c_slv.sv
// I2C target: address match, byte-wide rx/tx handshake, clock stretching.
module uv_i2c_slv
   import uv_i2c_pkg::*;
#(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         SYNC_STG = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl_in,
   output logic       i2c_scl_out,
   output logic       i2c_scl_oen,
   input  logic       i2c_sda_in,
   output logic       i2c_sda_out,
   output logic       i2c_sda_oen,
   output logic       rx_vld,
   input  logic       rx_rdy,
   output logic [7:0] rx_data,
   output logic       rx_first,
   input  logic       tx_vld,
   output logic       tx_rdy,
   input  logic [7:0] tx_data,
   output logic       bus_busy,
   output logic       evt_start,
   output logic       evt_stop,
   output logic       addr_hit,
   output logic       i2c_read_mode
);
   slv_state_e r_state, w_state_nxt;
   logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [3:0] r_bitcnt;
   logic [7:0] r_shift, r_rx_data;
   logic       r_sda_oen, r_scl_oen, r_rx_vld, r_rx_first, r_first_pend;
   logic       r_pend, r_stall, r_tx_rdy, r_busy, r_evt_start, r_evt_stop;
   logic       r_addr_hit, r_read_mode;
   logic       w_loadable, w_addr_ok;

   uv_i2c_slv_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk(clk), .rst(rst), .i_scl(i2c_scl_in), .i_sda(i2c_sda_in),
      .o_sda(w_sda), .o_scl_rise(w_scl_rise), .o_scl_fall(w_scl_fall),
      .o_start(w_start), .o_stop(w_stop)
   );

   assign w_loadable = ~r_rx_vld | rx_rdy;
   assign w_addr_ok  = (r_shift[6:0] == SLV_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_start)     w_state_nxt = ST_ADDR;
      else if (w_stop) w_state_nxt = ST_IDLE;
      else begin
         case (r_state)
            ST_ADDR:     if (w_scl_rise && r_bitcnt == LAST_BIT)
                            w_state_nxt = w_addr_ok ? ST_ADDR_ACK : ST_IGNORE;
            ST_ADDR_ACK: if (w_scl_fall && r_bitcnt == ACK_DONE)
                            w_state_nxt = r_read_mode ? ST_RD_LOAD : ST_WR_DATA;
            ST_WR_DATA:  if (w_scl_rise && r_bitcnt == LAST_BIT) w_state_nxt = ST_WR_ACK;
            ST_WR_ACK:   if (w_scl_fall && r_bitcnt == ACK_DONE) w_state_nxt = ST_WR_DATA;
            ST_RD_LOAD:  if (tx_vld) w_state_nxt = ST_RD_DATA;
            ST_RD_DATA:  if (w_scl_fall && r_bitcnt == LAST_BIT) w_state_nxt = ST_RD_ACK;
            ST_RD_ACK:   if (w_scl_fall)
                            w_state_nxt = (r_shift[0] == I2C_NACK) ? ST_IGNORE : ST_RD_LOAD;
            default:     w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bitcnt <= '0;  r_shift <= '0;  r_rx_data <= '0;
         r_sda_oen <= 1'b1;  r_scl_oen <= 1'b1;
         r_rx_vld <= 1'b0;  r_rx_first <= 1'b0;  r_first_pend <= 1'b0;
         r_pend <= 1'b0;  r_stall <= 1'b0;  r_tx_rdy <= 1'b0;  r_busy <= 1'b0;
         r_evt_start <= 1'b0;  r_evt_stop <= 1'b0;
         r_addr_hit <= 1'b0;  r_read_mode <= 1'b0;
      end else begin
         r_evt_start <= w_start;
         r_evt_stop  <= w_stop;
         r_addr_hit  <= 1'b0;
         r_tx_rdy    <= 1'b0;
         if (rx_rdy) r_rx_vld <= 1'b0;
         if (w_start || w_stop) begin
            r_sda_oen <= 1'b1;  r_scl_oen <= 1'b1;
            r_bitcnt  <= '0;    r_pend    <= 1'b0;  r_stall <= 1'b0;
            r_busy    <= w_start;
         end else begin
            case (r_state)
               ST_ADDR: if (w_scl_rise) begin
                  r_shift  <= {r_shift[6:0], w_sda};
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (r_bitcnt == LAST_BIT && w_addr_ok) begin
                     r_addr_hit   <= 1'b1;
                     r_read_mode  <= w_sda;
                     r_first_pend <= 1'b1;
                  end
               end
               ST_ADDR_ACK: if (w_scl_fall) begin
                  if (r_bitcnt == ACK_SLOT) begin
                     r_sda_oen <= I2C_ACK;
                     r_bitcnt  <= ACK_DONE;
                  end else begin
                     r_sda_oen <= 1'b1;
                     r_bitcnt  <= '0;
                     r_scl_oen <= ~r_read_mode;
                  end
               end
               ST_WR_DATA: if (w_scl_rise) begin
                  r_shift  <= {r_shift[6:0], w_sda};
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (r_bitcnt == LAST_BIT) begin
                     if (w_loadable) begin
                        r_rx_data    <= {r_shift[6:0], w_sda};
                        r_rx_vld     <= 1'b1;
                        r_rx_first   <= r_first_pend;
                        r_first_pend <= 1'b0;
                     end else r_pend <= 1'b1;
                  end
               end
               ST_WR_ACK: begin
                  if (r_pend && w_loadable) begin
                     r_rx_data    <= r_shift;
                     r_rx_vld     <= 1'b1;
                     r_rx_first   <= r_first_pend;
                     r_first_pend <= 1'b0;
                     r_pend       <= 1'b0;
                  end
                  // Hold SCL low from the 8th falling edge until the byte lands
                  if (r_bitcnt == ACK_SLOT && (w_scl_fall || r_stall)) begin
                     if (r_pend && !w_loadable) begin
                        r_scl_oen <= 1'b0;
                        r_stall   <= 1'b1;
                     end else begin
                        r_sda_oen <= I2C_ACK;
                        r_scl_oen <= 1'b1;
                        r_stall   <= 1'b0;
                        r_bitcnt  <= ACK_DONE;
                     end
                  end else if (r_bitcnt == ACK_DONE && w_scl_fall) begin
                     r_sda_oen <= 1'b1;
                     r_bitcnt  <= '0;
                  end
               end
               ST_RD_LOAD: begin
                  if (tx_vld) begin
                     r_shift   <= tx_data;
                     r_tx_rdy  <= 1'b1;
                     r_sda_oen <= tx_data[7];
                     r_scl_oen <= 1'b1;
                     r_bitcnt  <= '0;
                  end else r_scl_oen <= 1'b0;
               end
               ST_RD_DATA: if (w_scl_fall) begin
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (r_bitcnt == LAST_BIT) r_sda_oen <= 1'b1;
                  else begin
                     r_shift   <= {r_shift[6:0], 1'b0};
                     r_sda_oen <= r_shift[6];
                  end
               end
               ST_RD_ACK: begin
                  if (w_scl_rise) r_shift[RW_BIT] <= w_sda;
                  if (w_scl_fall) begin
                     r_bitcnt <= '0;
                     if (r_shift[0] == I2C_ACK) r_scl_oen <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign i2c_scl_out   = 1'b0;
   assign i2c_sda_out   = 1'b0;
   assign i2c_scl_oen   = r_scl_oen;
   assign i2c_sda_oen   = r_sda_oen;
   assign rx_vld        = r_rx_vld;
   assign rx_data       = r_rx_data;
   assign rx_first      = r_rx_first;
   assign tx_rdy        = r_tx_rdy;
   assign bus_busy      = r_busy;
   assign evt_start     = r_evt_start;
   assign evt_stop      = r_evt_stop;
   assign addr_hit      = r_addr_hit;
   assign i2c_read_mode = r_read_mode;
endmodule

// File: tb/tb_uv_i2c_slv.sv
// Directed bench: a bus-controller model drives open-drain SCL/SDA into the target.
module tb_uv_i2c_slv;
   logic       clk = 1'b0, rst = 1'b1;
   logic       m_scl = 1'b1, m_sda = 1'b1;
   logic       rx_rdy = 1'b0, tx_vld = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       scl_out, scl_oen, sda_out, sda_oen;
   logic       rx_vld, rx_first, tx_rdy, bus_busy, evt_start, evt_stop, addr_hit, read_mode;
   logic [7:0] rx_data;
   logic       w_scl, w_sda;
   int         n_chk = 0, n_pass = 0, n_fail = 0;

   assign w_scl = m_scl & scl_oen;
   assign w_sda = m_sda & sda_oen;

   always #5 clk = ~clk;

   uv_i2c_slv dut (
      .clk(clk), .rst(rst),
      .i2c_scl_in(w_scl), .i2c_scl_out(scl_out), .i2c_scl_oen(scl_oen),
      .i2c_sda_in(w_sda), .i2c_sda_out(sda_out), .i2c_sda_oen(sda_oen),
      .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_first(rx_first),
      .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_data(tx_data),
      .bus_busy(bus_busy), .evt_start(evt_start), .evt_stop(evt_stop),
      .addr_hit(addr_hit), .i2c_read_mode(read_mode)
   );

   // Event monitor: counts pulses and logs consumed rx bytes
   logic       mon_clr = 1'b0;
   int         n_start, n_stop, n_hit, n_txrdy, rx_n;
   logic [7:0] rx_q [8];
   logic       rx_f [8];
   logic       hit_rm [4];
   always @(posedge clk) begin
      if (mon_clr) begin
         n_start <= 0; n_stop <= 0; n_hit <= 0; n_txrdy <= 0; rx_n <= 0;
      end else begin
         if (evt_start) n_start <= n_start + 1;
         if (evt_stop)  n_stop  <= n_stop + 1;
         if (tx_rdy)    n_txrdy <= n_txrdy + 1;
         if (addr_hit) begin
            if (n_hit < 4) hit_rm[n_hit] <= read_mode;
            n_hit <= n_hit + 1;
         end
         if (rx_vld && rx_rdy) begin
            if (rx_n < 8) begin rx_q[rx_n] <= rx_data; rx_f[rx_n] <= rx_first; end
            rx_n <= rx_n + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_high();
      int n = 0;
      while (w_scl !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) chk("scl_release_timeout", {31'd0, w_scl}, 32'd1);
   endtask

   task automatic i2c_bit(input logic b, output logic s);
      wclk(5); m_sda = b; wclk(15); m_scl = 1'b1; wait_high();
      wclk(10); s = w_sda; wclk(10); m_scl = 1'b0;
   endtask

   task automatic i2c_start();
      wclk(5); m_sda = 1'b1; wclk(15); m_scl = 1'b1; wait_high();
      wclk(10); m_sda = 1'b0; wclk(10); m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wclk(5); m_sda = 1'b0; wclk(15); m_scl = 1'b1; wait_high();
      wclk(10); m_sda = 1'b1; wclk(10);
   endtask

   task automatic send_bits(input logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      send_bits(d);
      i2c_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin i2c_bit(1'b1, s); d[i] = s; end
      i2c_bit(mack, s);
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1; wclk(1); mon_clr = 1'b0;
   endtask

   logic       ack;
   logic [7:0] rd;

   initial begin
      // Reset state
      wclk(5); rst = 1'b0; wclk(2);
      chk("rst_scl_oen", {31'd0, scl_oen}, 32'd1);
      chk("rst_sda_oen", {31'd0, sda_oen}, 32'd1);
      chk("rst_outs", {28'd0, scl_out, sda_out, rx_vld, tx_rdy}, 32'd0);
      chk("rst_status", {29'd0, bus_busy, read_mode, addr_hit}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);

      // Write 0x3C with rx_rdy high
      rx_rdy = 1'b1; clr_mon();
      i2c_start();
      chk("t1_busy", {31'd0, bus_busy}, 32'd1);
      send_byte(8'hA0, ack); chk("t1_addr_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h3C, ack); chk("t1_data_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      chk("t1_rx_cnt", rx_n, 32'd1);
      chk("t1_rx_byte", {23'd0, rx_f[0], rx_q[0]}, 32'h13C);
      chk("t1_start_stop", {n_start[15:0], n_stop[15:0]}, 32'h0001_0001);
      chk("t1_idle_busy", {31'd0, bus_busy}, 32'd0);

      // Address mismatch 0x51
      clr_mon();
      i2c_start();
      send_byte(8'hA2, ack); chk("t2_addr_nack", {31'd0, ack}, 32'd1);
      send_byte(8'h55, ack); chk("t2_ignore_nack", {31'd0, ack}, 32'd1);
      i2c_stop();
      chk("t2_no_rx_hit", {rx_n[15:0], n_hit[15:0]}, 32'd0);

      // Read 0xA5, controller NACK
      tx_vld = 1'b1; tx_data = 8'hA5; clr_mon();
      i2c_start();
      send_byte(8'hA1, ack); chk("t3_addr_ack", {31'd0, ack}, 32'd1 - 32'd1);
      chk("t3_read_mode", {30'd0, read_mode, hit_rm[0]}, 32'd3);
      read_byte(1'b1, rd); chk("t3_rd_byte", {24'd0, rd}, 32'hA5);
      chk("t3_tx_rdy_cnt", n_txrdy, 32'd1);
      i2c_stop();
      chk("t3_idle", {30'd0, bus_busy, sda_oen}, 32'd1);
      tx_vld = 1'b0;

      // Back-pressure: second byte stretches until rx_rdy pulses
      rx_rdy = 1'b0; clr_mon();
      i2c_start();
      send_byte(8'hA0, ack); chk("t4_addr_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h11, ack); chk("t4_b1_ack", {31'd0, ack}, 32'd0);
      send_bits(8'h22); wclk(50);
      chk("t4_stretch", {31'd0, scl_oen}, 32'd0);
      chk("t4_hold_b1", {22'd0, rx_vld, rx_first, rx_data}, 32'h311);
      rx_rdy = 1'b1; wclk(1); rx_rdy = 1'b0; wclk(2);
      chk("t4_load_b2", {22'd0, rx_vld, rx_first, rx_data}, 32'h222);
      chk("t4_release", {31'd0, scl_oen}, 32'd1);
      i2c_bit(1'b1, ack); chk("t4_b2_ack", {31'd0, ack}, 32'd0);
      rx_rdy = 1'b1; i2c_stop();
      chk("t4_order", {rx_n[7:0], rx_q[0], rx_q[1]}, 32'h0002_1122);

      // Repeated START: write then read
      tx_vld = 1'b1; tx_data = 8'h5A; clr_mon();
      i2c_start();
      send_byte(8'hA0, ack); chk("t5_w_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h01, ack); chk("t5_d_ack", {31'd0, ack}, 32'd0);
      i2c_start();
      send_byte(8'hA1, ack); chk("t5_r_ack", {31'd0, ack}, 32'd0);
      read_byte(1'b1, rd); chk("t5_rd_byte", {24'd0, rd}, 32'h5A);
      i2c_stop();
      chk("t5_counts", {n_start[15:0], n_hit[15:0]}, 32'h0002_0002);
      chk("t5_rm_toggle", {30'd0, hit_rm[0], hit_rm[1]}, 32'd1);
      chk("t5_rx", {rx_n[15:0], 8'd0, rx_q[0]}, 32'h0001_0001);

      // Reset during the 5th bit of a read
      tx_data = 8'h00; clr_mon();
      i2c_start();
      send_byte(8'hA1, ack); chk("t6_addr_ack", {31'd0, ack}, 32'd0);
      for (int i = 0; i < 4; i++) i2c_bit(1'b1, ack);
      wclk(5); m_sda = 1'b1; wclk(10);
      chk("t6_driving", {31'd0, sda_oen}, 32'd0);
      rst = 1'b1; #1;
      chk("t6_async_rel", {30'd0, scl_oen, sda_oen}, 32'd3);
      wclk(3); rst = 1'b0; tx_vld = 1'b0; clr_mon();
      i2c_start();
      send_byte(8'hA0, ack); chk("t6_re_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h7E, ack);
      i2c_stop();
      chk("t6_rx", {rx_n[7:0], 7'd0, rx_f[0], 8'd0, rx_q[0]}, 32'h0101_007E);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
